rs_erasure_decode_sequencer: RTL and testbench

Controller for the RS(10,8) rank-level error/erasure decode datapath (8 data chips + 2 ECC chips, 8-bit symbols). It accepts one codeword plus a 10-bit per-chip DUE flag vector through a valid/ready handshake and counts the flagged chips. From that count it chooses one of three modes: error correction, two-symbol erasure correction, or immediate DUE. It then starts the external decode core, waits for completion with a timeout, and returns the result through a second valid/ready handshake.

---
 rtl/rs_erasure_decode_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_rs_erasure_decode_sequencer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_erasure_decode_sequencer.sv
// rtl/rs_erasure_decode_sequencer.sv - RS(10,8) error/erasure decode sequencer
// Optional saturating status counters are built when RS_SEQ_STATS_EN is defined.
module rs_erasure_decode_sequencer #(
    parameter int SYM_W   = 8,
    parameter int N_SYM   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SYM_W*N_SYM-1:0]         in_cw,
    input  logic [N_SYM-1:0]               in_due,
    output logic                           core_start,
    output logic [1:0]                     core_mode,
    output logic [SYM_W*N_SYM-1:0]         core_cw,
    output logic [3:0]                     core_era0,
    output logic [3:0]                     core_era1,
    input  logic                           core_done,
    input  logic                           core_fail,
    input  logic                           core_err,
    input  logic [SYM_W*(N_SYM-2)-1:0]     core_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SYM_W*(N_SYM-2)-1:0]     out_data,
    output logic [1:0]                     out_status
`ifdef RS_SEQ_STATS_EN
    ,
    output logic [15:0]                    stat_clean,
    output logic [15:0]                    stat_err,
    output logic [15:0]                    stat_era,
    output logic [15:0]                    stat_due
`endif
);

    localparam int DW = SYM_W * (N_SYM - 2);
    localparam int CW = SYM_W * N_SYM;

    localparam logic [1:0] MODE_ERR = 2'b00;
    localparam logic [1:0] MODE_ERA = 2'b01;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_ERA   = 2'b10;
    localparam logic [1:0] ST_DUE   = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            core_start_q;
    logic [1:0]      core_mode_q;
    logic [CW-1:0]   core_cw_q;
    logic [3:0]      core_era0_q;
    logic [3:0]      core_era1_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [1:0]      out_status_q;
    logic [7:0]      tmr_q;

    logic [3:0]      due_cnt_d;
    logic [3:0]      era_lo_d;
    logic [3:0]      era_hi_d;
    logic [1:0]      core_status_d;
    logic            accept;
    logic            resp_hs;

    // 4-bit accumulation keeps an all-chips-flagged vector (count 10) representable
    always_comb begin
        due_cnt_d = '0;
        for (int i = 0; i < N_SYM; i++) begin
            due_cnt_d = due_cnt_d + 4'(in_due[i]);
        end
    end

    always_comb begin
        era_lo_d = '0;
        era_hi_d = '0;
        for (int i = N_SYM - 1; i >= 0; i--) begin
            if (in_due[i]) era_lo_d = 4'(i);
        end
        for (int i = 0; i < N_SYM; i++) begin
            if (in_due[i]) era_hi_d = 4'(i);
        end
    end

    always_comb begin
        core_status_d = ST_CLEAN;
        if (core_fail) begin
            core_status_d = ST_DUE;
        end else if (core_err) begin
            core_status_d = (core_mode_q == MODE_ERA) ? ST_ERA : ST_ERR;
        end
    end

    assign accept  = (state_q == S_IDLE) && in_valid && in_ready_q;
    assign resp_hs = (state_q == S_RESP) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_mode_q  <= MODE_ERR;
            core_cw_q    <= '0;
            core_era0_q  <= '0;
            core_era1_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= ST_CLEAN;
            tmr_q        <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        core_cw_q  <= in_cw;
                        if (due_cnt_d >= 4'd3) begin
                            core_mode_q  <= MODE_ERR;
                            core_era0_q  <= '0;
                            core_era1_q  <= '0;
                            out_valid_q  <= 1'b1;
                            out_status_q <= ST_DUE;
                            out_data_q   <= '0;
                            state_q      <= S_RESP;
                        end else begin
                            if (due_cnt_d == 4'd2) begin
                                core_mode_q <= MODE_ERA;
                                core_era0_q <= era_lo_d;
                                core_era1_q <= era_hi_d;
                            end else begin
                                core_mode_q <= MODE_ERR;
                                core_era0_q <= '0;
                                core_era1_q <= '0;
                            end
                            core_start_q <= 1'b1;
                            state_q      <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // a completion in the timeout cycle still delivers its result
                    if (core_done) begin
                        out_valid_q  <= 1'b1;
                        out_status_q <= core_status_d;
                        out_data_q   <= (core_status_d == ST_DUE) ? '0 : core_data;
                        state_q      <= S_RESP;
                    end else if (tmr_q == TMO_LAST) begin
                        out_valid_q  <= 1'b1;
                        out_status_q <= ST_DUE;
                        out_data_q   <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_mode  = core_mode_q;
    assign core_cw    = core_cw_q;
    assign core_era0  = core_era0_q;
    assign core_era1  = core_era1_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;

`ifdef RS_SEQ_STATS_EN
    logic [15:0] stat_clean_q;
    logic [15:0] stat_err_q;
    logic [15:0] stat_era_q;
    logic [15:0] stat_due_q;

    // timeouts reach RESP as DUE, so they land in stat_due at handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_clean_q <= '0;
            stat_err_q   <= '0;
            stat_era_q   <= '0;
            stat_due_q   <= '0;
        end else if (resp_hs) begin
            case (out_status_q)
                ST_CLEAN: if (stat_clean_q != 16'hFFFF) stat_clean_q <= stat_clean_q + 16'd1;
                ST_ERR:   if (stat_err_q   != 16'hFFFF) stat_err_q   <= stat_err_q   + 16'd1;
                ST_ERA:   if (stat_era_q   != 16'hFFFF) stat_era_q   <= stat_era_q   + 16'd1;
                default:  if (stat_due_q   != 16'hFFFF) stat_due_q   <= stat_due_q   + 16'd1;
            endcase
        end
    end

    assign stat_clean = stat_clean_q;
    assign stat_err   = stat_err_q;
    assign stat_era   = stat_era_q;
    assign stat_due   = stat_due_q;
`else
    logic unused_hs;
    assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_rs_erasure_decode_sequencer.sv
// tb/tb_rs_erasure_decode_sequencer.sv - scoreboard bench for rs_erasure_decode_sequencer
module tb_rs_erasure_decode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_cw;
    logic [9:0]  in_due;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [79:0] core_cw;
    logic [3:0]  core_era0;
    logic [3:0]  core_era1;
    logic        core_done;
    logic        core_fail;
    logic        core_err;
    logic [63:0] core_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_status;
`ifdef RS_SEQ_STATS_EN
    logic [15:0] stat_clean;
    logic [15:0] stat_err;
    logic [15:0] stat_era;
    logic [15:0] stat_due;
`endif

    rs_erasure_decode_sequencer #(
        .SYM_W(8), .N_SYM(10), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw), .in_due(in_due),
        .core_start(core_start), .core_mode(core_mode), .core_cw(core_cw),
        .core_era0(core_era0), .core_era1(core_era1),
        .core_done(core_done), .core_fail(core_fail), .core_err(core_err), .core_data(core_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_status(out_status)
`ifdef RS_SEQ_STATS_EN
        ,
        .stat_clean(stat_clean), .stat_err(stat_err), .stat_era(stat_era), .stat_due(stat_due)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [65:0] exp_q[$];
    int vecs;
    int errs;
    int start_cnt;

    always @(posedge clk) begin
        if (rst_n && core_start) start_cnt++;
    end

    task automatic send(input logic [79:0] cw, input logic [9:0] due, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        in_cw = cw;
        in_due = due;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (core_start) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic core_reply(input int delay, input logic fail, input logic err, input logic [63:0] data);
        repeat (delay) @(negedge clk);
        core_done = 1'b1;
        core_fail = fail;
        core_err = err;
        core_data = data;
        @(negedge clk);
        core_done = 1'b0;
        core_fail = 1'b0;
        core_err = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_cw = '0; in_due = '0;
        core_done = 1'b0; core_fail = 1'b0; core_err = 1'b0; core_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0) begin
            errs++;
            $display("FAIL reset_handshake: got in_ready=%0b out_valid=%0b core_start=%0b, want 0 0 0", in_ready, out_valid, core_start);
        end
        vecs++;
        if (core_mode !== 2'b00 || core_era0 !== 4'd0 || core_era1 !== 4'd0 || core_cw !== 80'd0) begin
            errs++;
            $display("FAIL reset_core: got mode=%0b era0=%0d era1=%0d cw=%h, want all 0", core_mode, core_era0, core_era1, core_cw);
        end
        vecs++;
        if (out_data !== 64'd0 || out_status !== 2'b00) begin
            errs++;
            $display("FAIL reset_out: got data=%h status=%0b, want 0", out_data, out_status);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready: got %0b want 1", in_ready);
        end
`ifdef RS_SEQ_STATS_EN
        vecs++;
        if ({stat_clean, stat_err, stat_era, stat_due} !== 64'd0) begin
            errs++;
            $display("FAIL reset_stats: got %h want 0", {stat_clean, stat_err, stat_era, stat_due});
        end
`endif
    endtask

    task automatic test_clean();
        bit ok;
        int cyc;
        logic [65:0] e;
        logic [79:0] cw = 80'h1111_2222_3333_4444_5555;
        exp_q.push_back({2'b00, 64'h0123456789ABCDEF});
        send(cw, 10'h000, ok);
        wait_start(ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL clean_start: got no core_start, want pulse"); end
        vecs++;
        if (core_mode !== 2'b00 || core_cw !== cw) begin
            errs++;
            $display("FAIL clean_launch: got mode=%0b cw=%h, want 00 %h", core_mode, core_cw, cw);
        end
        core_reply(2, 1'b0, 1'b0, 64'h0123456789ABCDEF);
        wait_out(ok, cyc);
        vecs++;
        if (!ok || cyc != 0) begin
            errs++;
            $display("FAIL clean_latency: got valid=%0b after %0d extra cycles, want valid at 0", ok, cyc);
        end
        e = exp_q.pop_front();
        vecs++;
        if ({out_status, out_data} !== e) begin
            errs++;
            $display("FAIL clean_result: got %0b/%h want %0b/%h", out_status, out_data, e[65:64], e[63:0]);
        end
        accept_out();
    endtask

    task automatic test_error();
        bit ok;
        int cyc;
        int s0;
        logic [65:0] e;
        s0 = start_cnt;
        exp_q.push_back({2'b01, 64'hDEADBEEF_CAFEF00D});
        send(80'hABCD_0000_1234_5678_9ABC, 10'h001, ok);
        wait_start(ok);
        vecs++;
        if (!ok || core_mode !== 2'b00) begin
            errs++;
            $display("FAIL error_mode: got start=%0b mode=%0b, want 1 00", ok, core_mode);
        end
        core_reply(3, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D);
        wait_out(ok, cyc);
        e = exp_q.pop_front();
        vecs++;
        if (!ok || {out_status, out_data} !== e) begin
            errs++;
            $display("FAIL error_result: got %0b/%h want %0b/%h", out_status, out_data, e[65:64], e[63:0]);
        end
        vecs++;
        if (start_cnt - s0 != 1) begin
            errs++;
            $display("FAIL error_start_count: got %0d pulses want 1", start_cnt - s0);
        end
        accept_out();
    endtask

    task automatic test_erasure();
        bit ok;
        int cyc;
        logic [65:0] e;
        exp_q.push_back({2'b10, 64'hA5A5_5A5A_C3C3_3C3C});
        send(80'h9999_8888_7777_6666_5555, 10'h204, ok);
        wait_start(ok);
        vecs++;
        if (!ok || core_mode !== 2'b01 || core_era0 !== 4'd2 || core_era1 !== 4'd9) begin
            errs++;
            $display("FAIL erasure_launch: got mode=%0b era0=%0d era1=%0d, want 01 2 9", core_mode, core_era0, core_era1);
        end
        core_reply(1, 1'b0, 1'b1, 64'hA5A5_5A5A_C3C3_3C3C);
        wait_out(ok, cyc);
        vecs++;
        if (!ok || cyc != 0) begin
            errs++;
            $display("FAIL erasure_min_latency: got valid=%0b after %0d extra cycles, want valid at 0", ok, cyc);
        end
        e = exp_q.pop_front();
        vecs++;
        if ({out_status, out_data} !== e) begin
            errs++;
            $display("FAIL erasure_result: got %0b/%h want %0b/%h", out_status, out_data, e[65:64], e[63:0]);
        end
        vecs++;
        if (core_mode !== 2'b01 || core_era1 !== 4'd9) begin
            errs++;
            $display("FAIL erasure_mode_hold: got mode=%0b era1=%0d want 01 9", core_mode, core_era1);
        end
        accept_out();
    endtask

    task automatic test_due_bypass();
        bit ok;
        int s0;
        logic [65:0] e;
        logic [9:0] dues[3] = '{10'h007, 10'h3FF, 10'h2A8};
        foreach (dues[k]) begin
            s0 = start_cnt;
            exp_q.push_back({2'b11, 64'd0});
            send(80'h0F0F_F0F0_1234_4321_AAAA, dues[k], ok);
            vecs++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bypass_latency[%h]: got out_valid=%0b in_ready=%0b want 1 0", dues[k], out_valid, in_ready);
            end
            e = exp_q.pop_front();
            vecs++;
            if ({out_status, out_data} !== e) begin
                errs++;
                $display("FAIL bypass_result[%h]: got %0b/%h want %0b/%h", dues[k], out_status, out_data, e[65:64], e[63:0]);
            end
            @(negedge clk);
            vecs++;
            if (start_cnt != s0) begin
                errs++;
                $display("FAIL bypass_no_start[%h]: got %0d pulses want 0", dues[k], start_cnt - s0);
            end
            accept_out();
        end
    endtask

    task automatic test_core_fail();
        bit ok;
        int cyc;
        logic [65:0] e;
        exp_q.push_back({2'b11, 64'd0});
        send(80'h1234_5678_9ABC_DEF0_1357, 10'h100, ok);
        wait_start(ok);
        core_reply(2, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000);
        wait_out(ok, cyc);
        e = exp_q.pop_front();
        vecs++;
        if (!ok || {out_status, out_data} !== e) begin
            errs++;
            $display("FAIL core_fail_result: got %0b/%h want %0b/%h", out_status, out_data, e[65:64], e[63:0]);
        end
        accept_out();
    endtask

    task automatic test_timeout();
        bit ok;
        bit early;
        int cyc;
        logic [65:0] e;
        exp_q.push_back({2'b11, 64'd0});
        send(80'h5555_AAAA_5555_AAAA_5555, 10'h003, ok);
        wait_start(ok);
        vecs++;
        if (!ok || core_mode !== 2'b01 || core_era0 !== 4'd0 || core_era1 !== 4'd1) begin
            errs++;
            $display("FAIL timeout_launch: got mode=%0b era0=%0d era1=%0d want 01 0 1", core_mode, core_era0, core_era1);
        end
        early = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
        end
        vecs++;
        if (early) begin errs++; $display("FAIL timeout_early: got out_valid within 16 WAIT cycles, want 0"); end
        @(negedge clk);
        e = exp_q.pop_front();
        vecs++;
        if (out_valid !== 1'b1 || {out_status, out_data} !== e) begin
            errs++;
            $display("FAIL timeout_result: got v=%0b %0b/%h want 1 %0b/%h", out_valid, out_status, out_data, e[65:64], e[63:0]);
        end
        core_reply(0, 1'b0, 1'b1, 64'h1234_1234_1234_1234);
        vecs++;
        if (out_valid !== 1'b1 || out_status !== 2'b11 || out_data !== 64'd0) begin
            errs++;
            $display("FAIL timeout_late_done: got v=%0b %0b/%h want 1 11/0", out_valid, out_status, out_data);
        end
        accept_out();
        core_reply(0, 1'b0, 1'b1, 64'h7777_7777_7777_7777);
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL idle_done_ignored: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
        exp_q.push_back({2'b01, 64'h0BAD_F00D_0BAD_F00D});
        send(80'h0, 10'h000, ok);
        wait_start(ok);
        core_reply(16, 1'b0, 1'b1, 64'h0BAD_F00D_0BAD_F00D);
        wait_out(ok, cyc);
        e = exp_q.pop_front();
        vecs++;
        if (!ok || cyc != 0 || {out_status, out_data} !== e) begin
            errs++;
            $display("FAIL timeout_tie_done_wins: got %0b/%h cyc=%0d want %0b/%h cyc=0", out_status, out_data, cyc, e[65:64], e[63:0]);
        end
        accept_out();
    endtask

    task automatic test_stall_reset();
        bit ok;
        bit stable;
        bit quiet;
        int cyc;
        logic [65:0] e;
        exp_q.push_back({2'b00, 64'h0011_2233_4455_6677});
        send(80'hFEED_FACE_0000_1111_2222, 10'h000, ok);
        wait_start(ok);
        core_reply(2, 1'b0, 1'b0, 64'h0011_2233_4455_6677);
        wait_out(ok, cyc);
        e = exp_q.pop_front();
        vecs++;
        if (!ok || {out_status, out_data} !== e) begin
            errs++;
            $display("FAIL stall_result: got %0b/%h want %0b/%h", out_status, out_data, e[65:64], e[63:0]);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || {out_status, out_data} !== e || in_ready !== 1'b0) stable = 1'b0;
        end
        vecs++;
        if (!stable) begin
            errs++;
            $display("FAIL stall_hold: got v=%0b %0b/%h want 1 %0b/%h", out_valid, out_status, out_data, e[65:64], e[63:0]);
        end
        accept_out();
        send(80'hCAFE_CAFE_CAFE_CAFE_CAFE, 10'h001, ok);
        wait_start(ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0 || core_mode !== 2'b00 ||
            core_cw !== 80'd0 || core_era0 !== 4'd0 || core_era1 !== 4'd0 || out_data !== 64'd0 || out_status !== 2'b00) begin
            errs++;
            $display("FAIL midwait_reset: got rdy=%0b v=%0b st=%0b mode=%0b cw=%h data=%h want all 0",
                     in_ready, out_valid, core_start, core_mode, core_cw, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        core_reply(0, 1'b0, 1'b1, 64'h9999_9999_9999_9999);
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL post_reset_ready: got %0b want 1", in_ready);
        end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0 || out_data !== 64'd0) quiet = 1'b0;
            @(negedge clk);
        end
        vecs++;
        if (!quiet) begin
            errs++;
            $display("FAIL post_reset_done_ignored: got out_valid=%0b data=%h want 0 0", out_valid, out_data);
        end
`ifdef RS_SEQ_STATS_EN
        vecs++;
        if ({stat_clean, stat_err, stat_era, stat_due} !== 64'd0) begin
            errs++;
            $display("FAIL post_reset_stats: got %h want 0", {stat_clean, stat_err, stat_era, stat_due});
        end
`endif
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        start_cnt = 0;
        test_reset();
        test_clean();
        test_error();
        test_erasure();
        test_due_bypass();
        test_core_fail();
        test_timeout();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
